// File: rtl/led_pattern_gen_if.sv
// Bundle of the LED pattern generator's control and status signals.
//
// Signals (master = controller side, slave = led_pattern_gen):
//   en            master->slave  1       1 = run prescaler and step pattern, 0 = freeze
//   mode          master->slave  2       00 COUNT, 01 CHASE, 10 BOUNCE, 11 BLINK
//   dir           master->slave  1       0 = up/toward MSB, 1 = down/toward LSB
//   duty          master->slave  PWM_W   brightness (only with LED_PATTERN_PWM_EN)
//   led           slave->master  N_LEDS  LED drive, bit0 = LD0
//   tick          slave->master  1       one-cycle pulse coincident with each step
//   dbg_act_mode  slave->master  2       mode currently being executed
//   dbg_bdir      slave->master  1       BOUNCE travel direction (0 = up)
//
// Optional feature macro: LED_PATTERN_PWM_EN adds the duty signal.
//
// Handshake: there is no valid/ready pair. en is a level qualifier sampled
// every clock; tick is a single-cycle strobe with no back-pressure, marking
// the cycle in which led first shows a new pattern.
interface led_pattern_gen_if #(
  parameter int N_LEDS = 8,
  parameter int PWM_W  = 4
);
  logic              en;
  logic [1:0]        mode;
  logic              dir;
`ifdef LED_PATTERN_PWM_EN
  logic [PWM_W-1:0]  duty;
`endif
  logic [N_LEDS-1:0] led;
  logic              tick;
  logic [1:0]        dbg_act_mode;
  logic              dbg_bdir;

  if (N_LEDS < 2) begin : g_n_leds_chk
    $error("led_pattern_gen_if: N_LEDS must be >= 2");
  end
  if (PWM_W < 1) begin : g_pwm_w_chk
    $error("led_pattern_gen_if: PWM_W must be >= 1");
  end

`ifdef LED_PATTERN_PWM_EN
  modport master (output en, mode, dir, duty, input led, tick, dbg_act_mode, dbg_bdir);
  modport slave  (input en, mode, dir, duty, output led, tick, dbg_act_mode, dbg_bdir);
`else
  modport master (output en, mode, dir, input led, tick, dbg_act_mode, dbg_bdir);
  modport slave  (input en, mode, dir, output led, tick, dbg_act_mode, dbg_bdir);
`endif
endinterface

// File: rtl/led_pattern_gen.sv
// LED pattern generator for board bring-up and status display.
// A prescaler divides clk100mhz into step ticks; on each step the pattern
// advances in COUNT, CHASE, BOUNCE or BLINK mode.
//
// Ports:
//   clk100mhz  in   system clock
//   rst        in   synchronous, active-high reset
//   bus        led_pattern_gen_if.slave (en, mode, dir, [duty], led, tick, debug)
//
// Parameters: N_LEDS (>=2), DIV_MAX (step period = DIV_MAX+1 clocks),
//   CNT_W (prescaler width), PWM_W (PWM counter width).
// Optional feature macro: LED_PATTERN_PWM_EN -- adds duty input and a
//   free-running PWM counter that gates led.
module led_pattern_gen #(
  parameter int N_LEDS  = 8,
  parameter int DIV_MAX = 15_000_000,
  parameter int CNT_W   = 32,
  parameter int PWM_W   = 4
) (
  input logic              clk100mhz,
  input logic              rst,
  led_pattern_gen_if.slave bus
);

  typedef enum logic [1:0] {
    M_COUNT  = 2'b00,
    M_CHASE  = 2'b01,
    M_BOUNCE = 2'b10,
    M_BLINK  = 2'b11
  } mode_e;

  localparam logic [N_LEDS-1:0] P_ONE = {{(N_LEDS-1){1'b0}}, 1'b1};
  localparam logic [N_LEDS-1:0] P_ALL = {N_LEDS{1'b1}};

  if ((DIV_MAX < 0) || ((CNT_W < 63) && (longint'(DIV_MAX) >= (longint'(1) << CNT_W))))
  begin : g_div_chk
    $error("led_pattern_gen: DIV_MAX must fit in CNT_W bits");
  end
  if (PWM_W < 1) begin : g_pwm_chk
    $error("led_pattern_gen: PWM_W must be >= 1");
  end

  function automatic logic [N_LEDS-1:0] seed_of(input mode_e m);
    return (m == M_BLINK) ? P_ALL : P_ONE;
  endfunction

  logic [CNT_W-1:0]  r_cnt;
  logic [N_LEDS-1:0] r_pat;
  mode_e             r_act_mode;
  logic              r_bdir;      // 0 = moving toward MSB
  logic              r_tick;

  logic              w_step;
  mode_e             w_mode_in;
  logic              w_legal;
  logic [N_LEDS-1:0] w_next_pat;
  logic              w_next_bdir;

  assign w_mode_in = mode_e'(bus.mode);
  assign w_step    = bus.en && (r_cnt == CNT_W'(DIV_MAX));

  // Legality guards the pattern against upsets; from reset it always holds.
  always_comb begin
    w_legal = 1'b1;
    case (r_act_mode)
      M_COUNT:  w_legal = |r_pat;
      M_CHASE,
      M_BOUNCE: w_legal = $onehot(r_pat);
      M_BLINK:  w_legal = (&r_pat) || (~|r_pat);
      default:  w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_next_pat  = r_pat;
    w_next_bdir = r_bdir;
    if (w_mode_in != r_act_mode) begin
      // A mode change only reseeds; the first advance happens one step later.
      w_next_pat  = seed_of(w_mode_in);
      w_next_bdir = 1'b0;
    end else if (!w_legal) begin
      w_next_pat  = seed_of(r_act_mode);
      w_next_bdir = 1'b0;
    end else begin
      case (r_act_mode)
        M_COUNT: begin
          if (!bus.dir) w_next_pat = (&r_pat) ? P_ONE : r_pat + N_LEDS'(1);
          else          w_next_pat = (r_pat == P_ONE) ? P_ALL : r_pat - N_LEDS'(1);
        end
        M_CHASE: begin
          if (!bus.dir) w_next_pat = {r_pat[N_LEDS-2:0], r_pat[N_LEDS-1]};
          else          w_next_pat = {r_pat[0], r_pat[N_LEDS-1:1]};
        end
        M_BOUNCE: begin
          // End positions turn around immediately so each end shows for one step.
          if (r_pat[N_LEDS-1]) begin
            w_next_pat  = r_pat >> 1;
            w_next_bdir = 1'b1;
          end else if (r_pat[0]) begin
            w_next_pat  = r_pat << 1;
            w_next_bdir = 1'b0;
          end else begin
            w_next_pat  = r_bdir ? (r_pat >> 1) : (r_pat << 1);
          end
        end
        M_BLINK:  w_next_pat = ~r_pat;
        default:  w_next_pat = seed_of(r_act_mode);
      endcase
    end
  end

  always_ff @(posedge clk100mhz) begin
    if (rst) begin
      r_cnt      <= '0;
      r_pat      <= P_ONE;
      r_act_mode <= M_COUNT;
      r_bdir     <= 1'b0;
      r_tick     <= 1'b0;
    end else begin
      r_tick <= w_step;
      if (bus.en) begin
        r_cnt <= w_step ? '0 : r_cnt + CNT_W'(1);
      end
      if (w_step) begin
        r_pat      <= w_next_pat;
        r_bdir     <= w_next_bdir;
        r_act_mode <= w_mode_in;
      end
    end
  end

`ifdef LED_PATTERN_PWM_EN
  logic [PWM_W-1:0] r_pwm_cnt;
  logic             w_pwm_on;

  // Free-runs independent of en so a frozen pattern keeps its brightness.
  always_ff @(posedge clk100mhz) begin
    if (rst) r_pwm_cnt <= '0;
    else     r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
  end

  assign w_pwm_on = (r_pwm_cnt < bus.duty);
  assign bus.led  = r_pat & {N_LEDS{w_pwm_on}};
`else
  assign bus.led  = r_pat;
`endif

  assign bus.tick         = r_tick;
  assign bus.dbg_act_mode = r_act_mode;
  assign bus.dbg_bdir     = r_bdir;

endmodule

// File: tb/tb_led_pattern_gen.sv
module tb_led_pattern_gen;
  localparam int N  = 8;
  localparam int DM = 3;
  localparam int PW = 4;

  // ---------------- clock / reset ----------------
  logic clk100mhz = 1'b0;
  logic rst       = 1'b1;
  always #5 clk100mhz = ~clk100mhz;

  led_pattern_gen_if #(.N_LEDS(N), .PWM_W(PW)) bus ();

  led_pattern_gen #(.N_LEDS(N), .DIV_MAX(DM), .CNT_W(32), .PWM_W(PW)) dut (
    .clk100mhz (clk100mhz),
    .rst       (rst),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [N-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // Patterns are tracked as abstract positions/values, not as shift registers.
  int m_mode, m_cval, m_cpos, m_bk, m_blink, m_phase, m_pwm;
  bit m_tick;

  function automatic logic [N-1:0] model_pat();
    logic [N-1:0] p;
    int pos;
    case (m_mode)
      0: p = m_cval[N-1:0];
      1: p = N'(1) << m_cpos;
      2: begin
        pos = (m_bk < N) ? m_bk : (2 * N - 2 - m_bk);
        p = N'(1) << pos;
      end
      default: p = m_blink ? {N{1'b1}} : {N{1'b0}};
    endcase
    return p;
  endfunction

  function automatic logic [N-1:0] pwm_mask();
`ifdef LED_PATTERN_PWM_EN
    return (m_pwm < int'(bus.duty)) ? {N{1'b1}} : {N{1'b0}};
`else
    return {N{1'b1}};
`endif
  endfunction

  task automatic model_step();
    if (int'(bus.mode) != m_mode) begin
      m_mode = int'(bus.mode);
      m_cval = 1; m_cpos = 0; m_bk = 0; m_blink = 1;
    end else begin
      case (m_mode)
        0: m_cval = bus.dir ? (((m_cval - 2 + 255) % 255) + 1) : ((m_cval % 255) + 1);
        1: m_cpos = bus.dir ? ((m_cpos + N - 1) % N) : ((m_cpos + 1) % N);
        2: m_bk   = (m_bk + 1) % (2 * N - 2);
        default: m_blink = !m_blink;
      endcase
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_mode = 0; m_cval = 1; m_cpos = 0; m_bk = 0; m_blink = 1;
      m_phase = 0; m_tick = 0; m_pwm = 0;
    end else begin
      m_pwm  = (m_pwm + 1) % (1 << PW);
      m_tick = 0;
      if (bus.en) begin
        if (m_phase == DM) begin
          m_phase = 0;
          m_tick  = 1;
          model_step();
        end else begin
          m_phase++;
        end
      end
    end
  endtask

  // ---------------- scoreboard / driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk100mhz);
    model_update();
    exp_q.push_back(model_pat() & pwm_mask());
    #1;
    check("led", 32'(bus.led), 32'(exp_q.pop_front()));
    check("tick", 32'(bus.tick), 32'(m_tick));
  endtask

  task automatic run_to_tick(output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!m_tick && n < 40);
    if (!m_tick) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: no step within %0d cycles", n);
    end
  endtask

  typedef struct {
    logic [1:0]   mode;
    logic         dir;
    logic [N-1:0] exp_led;
  } vec_t;

  vec_t tbl[27];
  logic [N-1:0] bounce_exp[15];

  initial begin
    int n;
    int hits;
    logic [N-1:0] held;

    tbl[0]  = '{2'b00, 1'b0, 8'h02}; tbl[1]  = '{2'b00, 1'b0, 8'h03};
    tbl[2]  = '{2'b00, 1'b0, 8'h04}; tbl[3]  = '{2'b00, 1'b1, 8'h03};
    tbl[4]  = '{2'b00, 1'b1, 8'h02}; tbl[5]  = '{2'b00, 1'b1, 8'h01};
    tbl[6]  = '{2'b00, 1'b1, 8'hFF}; tbl[7]  = '{2'b00, 1'b1, 8'hFE};
    tbl[8]  = '{2'b00, 1'b0, 8'hFF}; tbl[9]  = '{2'b00, 1'b0, 8'h01};
    tbl[10] = '{2'b01, 1'b0, 8'h01}; tbl[11] = '{2'b01, 1'b0, 8'h02};
    tbl[12] = '{2'b01, 1'b0, 8'h04}; tbl[13] = '{2'b01, 1'b1, 8'h02};
    tbl[14] = '{2'b01, 1'b1, 8'h01}; tbl[15] = '{2'b01, 1'b1, 8'h80};
    tbl[16] = '{2'b01, 1'b1, 8'h40}; tbl[17] = '{2'b01, 1'b0, 8'h80};
    tbl[18] = '{2'b01, 1'b0, 8'h01}; tbl[19] = '{2'b10, 1'b1, 8'h01};
    tbl[20] = '{2'b10, 1'b0, 8'h02}; tbl[21] = '{2'b10, 1'b1, 8'h04};
    tbl[22] = '{2'b11, 1'b0, 8'hFF}; tbl[23] = '{2'b11, 1'b1, 8'h00};
    tbl[24] = '{2'b11, 1'b0, 8'hFF}; tbl[25] = '{2'b00, 1'b0, 8'h01};
    tbl[26] = '{2'b00, 1'b0, 8'h02};

    bounce_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                   8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

    bus.en   = 1'b1;
    bus.mode = 2'b00;
    bus.dir  = 1'b0;
`ifdef LED_PATTERN_PWM_EN
    bus.duty = 4'hF;
`endif

    // Reset for two cycles
    rst = 1'b1;
    cycle();
    cycle();
    check("reset_led", 32'(bus.led & 8'hFF), 32'(8'h01 & pwm_mask()));
    check("reset_tick", 32'(bus.tick), 32'd0);
    rst = 1'b0;

    // Table-driven steps
    for (int i = 0; i < 27; i++) begin
      bus.mode = tbl[i].mode;
      bus.dir  = tbl[i].dir;
      run_to_tick(n);
      check($sformatf("vec%0d_led", i), 32'(bus.led), 32'(tbl[i].exp_led & pwm_mask()));
      check($sformatf("vec%0d_period", i), 32'(n), 32'(DM + 1));
    end

    // COUNT to 05, then switch to BLINK mid-period
    bus.mode = 2'b00; bus.dir = 1'b0;
    repeat (3) run_to_tick(n);
    check("count05", 32'(bus.led), 32'(8'h05 & pwm_mask()));
    cycle();
    bus.mode = 2'b11;
    run_to_tick(n);
    check("blink_seed_period", 32'(n), 32'(DM));
    check("blink_seed", 32'(bus.led), 32'(8'hFF & pwm_mask()));
    run_to_tick(n);
    check("blink_off", 32'(bus.led), 32'(8'h00));
    run_to_tick(n);
    check("blink_on", 32'(bus.led), 32'(8'hFF & pwm_mask()));

    // Freeze with en=0 mid-period, then resume
    cycle();
    held = model_pat();
    bus.en = 1'b0;
    repeat (10) cycle();
    check("freeze_held", 32'(model_pat()), 32'(held));
    bus.en = 1'b1;
    run_to_tick(n);
    check("resume_period", 32'(n), 32'(DM));
    check("resume_led", 32'(bus.led), 32'(8'h00));

    // Reset mid-period aborts the period
    bus.mode = 2'b00;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("midrst_led", 32'(bus.led), 32'(8'h01 & pwm_mask()));
    run_to_tick(n);
    check("midrst_period", 32'(n), 32'(DM + 1));
    check("midrst_step", 32'(bus.led), 32'(8'h02 & pwm_mask()));

    // Full BOUNCE sweep with dir toggling randomly
    bus.mode = 2'b10;
    run_to_tick(n);
    check("bounce_seed", 32'(bus.led), 32'(8'h01 & pwm_mask()));
    for (int i = 0; i < 15; i++) begin
      bus.dir = 1'($urandom_range(0, 1));
      run_to_tick(n);
      check($sformatf("bounce%0d", i), 32'(bus.led), 32'(bounce_exp[i] & pwm_mask()));
    end

    // Randomized run against the model
    for (int i = 0; i < 600; i++) begin
      bus.en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 25) == 0) bus.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)  bus.dir  = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0;
    bus.en = 1'b1;

`ifdef LED_PATTERN_PWM_EN
    // PWM: BLINK frozen at all-ones
    bus.mode = 2'b11;
    run_to_tick(n);
    if (!m_blink) run_to_tick(n);
    bus.en = 1'b0;
    bus.duty = 4'd4;
    hits = 0;
    repeat (16) begin
      cycle();
      if (bus.led == 8'hFF) hits++;
    end
    check("pwm_duty4", 32'(hits), 32'd4);
    bus.duty = 4'd0;
    hits = 0;
    repeat (16) begin
      cycle();
      if (bus.led != 8'h00) hits++;
    end
    check("pwm_duty0", 32'(hits), 32'd0);
`else
    hits = 0;
    held = '0;
`endif

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
